// File: rtl/hilo_control.sv
// hilo_control: sequences the multi-cycle multiplier and divider and owns the
// architectural HI/LO registers.
//
// A start request in IDLE runs the selected unit for a fixed number of cycles.
// The result is latched into HI/LO in a one-cycle CAPTURE state, and a
// one-cycle DONE state then reports completion. MTHI/MTLO-style direct writes
// are accepted only in IDLE. Every output comes straight from a flop, so the
// control unit sees glitch-free status.
module hilo_control #(
    parameter int unsigned MULT_CYCLES = 34,
    parameter int unsigned DIV_CYCLES  = 34
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start_Mult,
    input  logic        Start_Div,
    input  logic [31:0] Mult_HI,
    input  logic [31:0] Mult_LO,
    input  logic [31:0] Div_HI,
    input  logic [31:0] Div_LO,
    input  logic        Div_Zero,
    input  logic        Write_HI,
    input  logic        Write_LO,
    input  logic [31:0] Data_In,
    output logic        Mult_Control,
    output logic        Div_Control,
    output logic        Busy,
    output logic        Done,
    output logic        Div_Zero_Exc,
    output logic [31:0] HI_Out,
    output logic [31:0] LO_Out
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN_MULT = 3'd1,
        RUN_DIV  = 3'd2,
        CAPTURE  = 3'd3,
        DONE     = 3'd4
    } state_t;

    // Last counter value of a run. The counter starts at 0 on the start edge,
    // so the unit enable stays high for exactly N cycles. Six bits cover
    // N up to 63 without the counter ever wrapping.
    localparam logic [5:0] MULT_LAST = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_LAST  = 6'(DIV_CYCLES - 1);

    // Operation-select encoding. Multiply is 0 so that reset leaves op at 0.
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    state_t      state_reg;
    logic [5:0]  count_reg;
    logic        op_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        mult_ctrl_reg;
    logic        div_ctrl_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        exc_reg;

    // Control FSM, cycle counter, HI/LO storage and registered status outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg     <= IDLE;
            count_reg     <= 6'd0;
            op_reg        <= OP_MULT;
            hi_reg        <= 32'd0;
            lo_reg        <= 32'd0;
            mult_ctrl_reg <= 1'b0;
            div_ctrl_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            exc_reg       <= 1'b0;
        end else begin
            // Done and the divide-by-zero flag are pulses. Only the
            // CAPTURE -> DONE transition re-arms them.
            done_reg <= 1'b0;
            exc_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    // Direct writes and a start can share the same edge. The
                    // write lands now, and CAPTURE overwrites it later.
                    if (Write_HI) begin
                        hi_reg <= Data_In;
                    end
                    if (Write_LO) begin
                        lo_reg <= Data_In;
                    end
                    // Multiply wins when both starts arrive together. The
                    // divide request is dropped, not queued.
                    if (Start_Mult) begin
                        state_reg     <= RUN_MULT;
                        count_reg     <= 6'd0;
                        op_reg        <= OP_MULT;
                        mult_ctrl_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                    end else if (Start_Div) begin
                        state_reg    <= RUN_DIV;
                        count_reg    <= 6'd0;
                        op_reg       <= OP_DIV;
                        div_ctrl_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end

                RUN_MULT: begin
                    if (count_reg == MULT_LAST) begin
                        state_reg     <= CAPTURE;
                        mult_ctrl_reg <= 1'b0;
                    end else begin
                        count_reg <= count_reg + 6'd1;
                    end
                end

                RUN_DIV: begin
                    if (count_reg == DIV_LAST) begin
                        state_reg    <= CAPTURE;
                        div_ctrl_reg <= 1'b0;
                    end else begin
                        count_reg <= count_reg + 6'd1;
                    end
                end

                CAPTURE: begin
                    // A zero divisor leaves HI/LO untouched and raises the
                    // exception pulse alongside Done.
                    if (op_reg == OP_MULT) begin
                        hi_reg <= Mult_HI;
                        lo_reg <= Mult_LO;
                    end else if (!Div_Zero) begin
                        hi_reg <= Div_HI;
                        lo_reg <= Div_LO;
                    end else begin
                        exc_reg <= 1'b1;
                    end
                    state_reg <= DONE;
                    count_reg <= 6'd0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end

                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    // Unreachable encodings recover to a quiet IDLE.
                    state_reg     <= IDLE;
                    count_reg     <= 6'd0;
                    mult_ctrl_reg <= 1'b0;
                    div_ctrl_reg  <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign Mult_Control = mult_ctrl_reg;
    assign Div_Control  = div_ctrl_reg;
    assign Busy         = busy_reg;
    assign Done         = done_reg;
    assign Div_Zero_Exc = exc_reg;
    assign HI_Out       = hi_reg;
    assign LO_Out       = lo_reg;

endmodule

// File: tb/tb_hilo_control.sv
// tb_hilo_control: scenario tasks plus randomized operations.
// Results are checked against a small HI/LO model and against cycle-count
// expectations derived from the run length N.
module tb_hilo_control;

    localparam int N = 34;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start_Mult, Start_Div;
    logic [31:0] Mult_HI, Mult_LO, Div_HI, Div_LO;
    logic        Div_Zero;
    logic        Write_HI, Write_LO;
    logic [31:0] Data_In;
    logic        Mult_Control, Div_Control, Busy, Done, Div_Zero_Exc;
    logic [31:0] HI_Out, LO_Out;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model of the architectural registers.
    logic [31:0] hi_m, lo_m;

    // Observations from the most recent run_op.
    int r_mc, r_dc, r_bc, r_dn, r_di, r_ec, r_ei;
    bit r_to, r_hi_moved;

    hilo_control #(.MULT_CYCLES(N), .DIV_CYCLES(N)) dut (
        .Clock(Clock), .Reset(Reset),
        .Start_Mult(Start_Mult), .Start_Div(Start_Div),
        .Mult_HI(Mult_HI), .Mult_LO(Mult_LO),
        .Div_HI(Div_HI), .Div_LO(Div_LO), .Div_Zero(Div_Zero),
        .Write_HI(Write_HI), .Write_LO(Write_LO), .Data_In(Data_In),
        .Mult_Control(Mult_Control), .Div_Control(Div_Control),
        .Busy(Busy), .Done(Done), .Div_Zero_Exc(Div_Zero_Exc),
        .HI_Out(HI_Out), .LO_Out(LO_Out)
    );

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Direct write in IDLE; called and returns just after a negedge.
    task automatic do_write(input bit wh, input bit wl, input logic [31:0] d);
        Write_HI = wh; Write_LO = wl; Data_In = d;
        @(negedge Clock);
        Write_HI = 1'b0; Write_LO = 1'b0;
        if (wh) hi_m = d;
        if (wl) lo_m = d;
        $display("write  HI=%0b LO=%0b data=%08h -> HI_Out=%08h LO_Out=%08h", wh, wl, d, HI_Out, LO_Out);
    endtask

    // Issue a start, then observe one sample per cycle until Done has come and gone.
    // Sample e is taken after edge e; edge 0 is the start edge.
    task automatic run_op(input bit sm, input bit sd, input bit noise);
        logic [31:0] hi_start;
        r_mc = 0; r_dc = 0; r_bc = 0; r_dn = 0; r_ec = 0;
        r_di = -1; r_ei = -1; r_to = 1'b1; r_hi_moved = 1'b0;
        hi_start = HI_Out;
        Start_Mult = sm; Start_Div = sd;
        @(negedge Clock);
        Start_Mult = 1'b0; Start_Div = 1'b0;
        for (int e = 0; e < 4 * N; e++) begin
            if (e > 0) @(negedge Clock);
            r_mc += Mult_Control ? 1 : 0;
            r_dc += Div_Control ? 1 : 0;
            r_bc += Busy ? 1 : 0;
            if (e <= N && HI_Out !== hi_start) r_hi_moved = 1'b1;
            if (Done) begin r_dn++; r_di = e; end
            if (Div_Zero_Exc) begin r_ec++; r_ei = e; end
            if (noise) begin
                if (e == 5) begin
                    Start_Mult = 1'b1; Write_HI = 1'b1; Data_In = 32'hDEADBEEF;
                end else if (e == 6) begin
                    Start_Mult = 1'b0; Write_HI = 1'b0;
                end
            end
            if (r_dn > 0 && !Done) begin r_to = 1'b0; break; end
        end
        $display("op     mult=%0b div=%0b mc=%0d dc=%0d busy=%0d done@%0d exc=%0d HI=%08h LO=%08h",
                 sm, sd, r_mc, r_dc, r_bc, r_di, r_ec, HI_Out, LO_Out);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        #1;
        vectors++;
        if ({HI_Out, LO_Out, Mult_Control, Div_Control, Busy, Done, Div_Zero_Exc} !== 69'd0) begin
            miscompares++;
            $display("FAIL reset_state: got HI=%08h LO=%08h mc=%b dc=%b busy=%b done=%b exc=%b, expected all 0",
                     HI_Out, LO_Out, Mult_Control, Div_Control, Busy, Done, Div_Zero_Exc);
        end
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        hi_m = 32'd0; lo_m = 32'd0;
        v = $urandom | 32'h1;
        do_write(1'b1, 1'b1, v);
        // Assert reset mid-cycle: registers must clear before the next edge.
        #2 Reset = 1'b1;
        #1;
        vectors++;
        if (HI_Out !== 32'd0 || LO_Out !== 32'd0) begin
            miscompares++;
            $display("FAIL async_reset_idle: got HI=%08h LO=%08h, expected 0/0", HI_Out, LO_Out);
        end
        hi_m = 32'd0; lo_m = 32'd0;
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        $display("reset  HI=%08h LO=%08h busy=%b", HI_Out, LO_Out, Busy);
    endtask

    task automatic test_direct_write();
        do_write(1'b1, 1'b1, 32'hCAFEF00D);
        vectors++;
        if (HI_Out !== 32'hCAFEF00D || LO_Out !== 32'hCAFEF00D || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL write_both: got HI=%08h LO=%08h busy=%b, expected CAFEF00D/CAFEF00D/0", HI_Out, LO_Out, Busy);
        end
        do_write(1'b1, 1'b0, 32'h12345678);
        vectors++;
        if (HI_Out !== 32'h12345678 || LO_Out !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL write_hi_only: got HI=%08h LO=%08h, expected 12345678/CAFEF00D", HI_Out, LO_Out);
        end
        do_write(1'b0, 1'b1, 32'h0BADF00D);
        vectors++;
        if (HI_Out !== 32'h12345678 || LO_Out !== 32'h0BADF00D) begin
            miscompares++;
            $display("FAIL write_lo_only: got HI=%08h LO=%08h, expected 12345678/0BADF00D", HI_Out, LO_Out);
        end
    endtask

    task automatic test_mult();
        Mult_HI = 32'h0; Mult_LO = 32'h6;
        run_op(1'b1, 1'b0, 1'b0);
        hi_m = 32'h0; lo_m = 32'h6;
        vectors++;
        if (r_mc !== N) begin miscompares++; $display("FAIL mult_control_len: got %0d expected %0d", r_mc, N); end
        vectors++;
        if (r_bc !== N + 1) begin miscompares++; $display("FAIL mult_busy_len: got %0d expected %0d", r_bc, N + 1); end
        vectors++;
        if (r_dn !== 1 || r_di !== N + 1) begin
            miscompares++; $display("FAIL mult_done: got count=%0d at=%0d expected 1 at %0d", r_dn, r_di, N + 1);
        end
        vectors++;
        if (r_dc !== 0 || r_ec !== 0 || r_to) begin
            miscompares++; $display("FAIL mult_side: got dc=%0d exc=%0d timeout=%0b expected 0/0/0", r_dc, r_ec, r_to);
        end
        vectors++;
        if (HI_Out !== hi_m || LO_Out !== lo_m) begin
            miscompares++; $display("FAIL mult_result: got %08h/%08h expected %08h/%08h", HI_Out, LO_Out, hi_m, lo_m);
        end
    endtask

    task automatic test_div_zero();
        do_write(1'b1, 1'b0, 32'h11);
        do_write(1'b0, 1'b1, 32'h22);
        Div_HI = $urandom; Div_LO = $urandom; Div_Zero = 1'b1;
        run_op(1'b0, 1'b1, 1'b0);
        Div_Zero = 1'b0;
        vectors++;
        if (r_dc !== N || r_mc !== 0) begin
            miscompares++; $display("FAIL divz_control: got dc=%0d mc=%0d expected %0d/0", r_dc, r_mc, N);
        end
        vectors++;
        if (r_ec !== 1 || r_ei !== N + 1 || r_di !== N + 1 || r_dn !== 1) begin
            miscompares++;
            $display("FAIL divz_pulses: got exc=%0d@%0d done=%0d@%0d expected 1@%0d", r_ec, r_ei, r_dn, r_di, N + 1);
        end
        vectors++;
        if (HI_Out !== 32'h11 || LO_Out !== 32'h22) begin
            miscompares++; $display("FAIL divz_hilo: got %08h/%08h expected 00000011/00000022", HI_Out, LO_Out);
        end
    endtask

    task automatic test_same_edge();
        Mult_HI = $urandom; Mult_LO = $urandom;
        Div_HI = $urandom; Div_LO = $urandom;
        run_op(1'b1, 1'b1, 1'b0);
        hi_m = Mult_HI; lo_m = Mult_LO;
        vectors++;
        if (r_mc !== N || r_dc !== 0) begin
            miscompares++; $display("FAIL same_edge_ctrl: got mc=%0d dc=%0d expected %0d/0", r_mc, r_dc, N);
        end
        vectors++;
        if (HI_Out !== hi_m || LO_Out !== lo_m) begin
            miscompares++; $display("FAIL same_edge_result: got %08h/%08h expected %08h/%08h", HI_Out, LO_Out, hi_m, lo_m);
        end
    endtask

    task automatic test_ignore_during_run();
        Div_HI = $urandom; Div_LO = $urandom; Div_Zero = 1'b0;
        run_op(1'b0, 1'b1, 1'b1);
        hi_m = Div_HI; lo_m = Div_LO;
        vectors++;
        if (r_mc !== 0 || r_dc !== N) begin
            miscompares++; $display("FAIL ignore_start: got mc=%0d dc=%0d expected 0/%0d", r_mc, r_dc, N);
        end
        vectors++;
        if (r_hi_moved !== 1'b0) begin
            miscompares++; $display("FAIL ignore_write: got HI changed=%0b before capture, expected 0", r_hi_moved);
        end
        vectors++;
        if (HI_Out !== hi_m || LO_Out !== lo_m) begin
            miscompares++; $display("FAIL ignore_result: got %08h/%08h expected %08h/%08h", HI_Out, LO_Out, hi_m, lo_m);
        end
        repeat (3) @(negedge Clock);
        vectors++;
        if (Busy !== 1'b0 || Mult_Control !== 1'b0) begin
            miscompares++; $display("FAIL ignore_no_restart: got busy=%b mc=%b expected 0/0", Busy, Mult_Control);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        do_write(1'b1, 1'b1, $urandom | 32'h1);
        Mult_HI = $urandom; Mult_LO = $urandom;
        Start_Mult = 1'b1;
        @(negedge Clock);
        Start_Mult = 1'b0;
        repeat (10) @(negedge Clock);
        #2 Reset = 1'b1;
        #1;
        vectors++;
        if (Mult_Control !== 1'b0 || Busy !== 1'b0 || HI_Out !== 32'd0 || LO_Out !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid_run: got mc=%b busy=%b HI=%08h LO=%08h expected all 0", Mult_Control, Busy, HI_Out, LO_Out);
        end
        hi_m = 32'd0; lo_m = 32'd0;
        @(negedge Clock);
        Reset = 1'b0;
        dones = 0;
        for (int i = 0; i < N + 10; i++) begin
            @(negedge Clock);
            if (Done || Busy) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++; $display("FAIL reset_abort: got %0d Done/Busy cycles after reset expected 0", dones);
        end
        Mult_HI = $urandom; Mult_LO = $urandom;
        run_op(1'b1, 1'b0, 1'b0);
        hi_m = Mult_HI; lo_m = Mult_LO;
        vectors++;
        if (r_mc !== N || r_di !== N + 1 || HI_Out !== hi_m || LO_Out !== lo_m) begin
            miscompares++;
            $display("FAIL post_reset_run: got mc=%0d done@%0d HI=%08h LO=%08h expected %0d @%0d %08h/%08h",
                     r_mc, r_di, HI_Out, LO_Out, N, N + 1, hi_m, lo_m);
        end
    endtask

    task automatic test_random();
        int kind;
        bit sm, sd, is_mult, dz;
        int exp_ec;
        for (int it = 0; it < 12; it++) begin
            kind = $urandom_range(0, 2);
            sm = (kind != 1);
            sd = (kind != 0);
            is_mult = sm;
            dz = 1'($urandom_range(0, 1));
            Mult_HI = $urandom; Mult_LO = $urandom;
            Div_HI = $urandom; Div_LO = $urandom;
            Div_Zero = dz;
            if ($urandom_range(0, 1) == 1)
                do_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            run_op(sm, sd, 1'b0);
            exp_ec = 0;
            if (is_mult) begin
                hi_m = Mult_HI; lo_m = Mult_LO;
            end else if (!dz) begin
                hi_m = Div_HI; lo_m = Div_LO;
            end else begin
                exp_ec = 1;
            end
            Div_Zero = 1'b0;
            vectors++;
            if (r_mc !== (is_mult ? N : 0) || r_dc !== (is_mult ? 0 : N)) begin
                miscompares++;
                $display("FAIL rand%0d_ctrl: got mc=%0d dc=%0d expected %0d/%0d", it, r_mc, r_dc, is_mult ? N : 0, is_mult ? 0 : N);
            end
            vectors++;
            if (r_bc !== N + 1 || r_dn !== 1 || r_di !== N + 1 || r_to) begin
                miscompares++;
                $display("FAIL rand%0d_timing: got busy=%0d done=%0d@%0d timeout=%0b expected %0d 1@%0d 0",
                         it, r_bc, r_dn, r_di, r_to, N + 1, N + 1);
            end
            vectors++;
            if (r_ec !== exp_ec || (exp_ec == 1 && r_ei !== N + 1)) begin
                miscompares++; $display("FAIL rand%0d_exc: got %0d@%0d expected %0d@%0d", it, r_ec, r_ei, exp_ec, N + 1);
            end
            vectors++;
            if (HI_Out !== hi_m || LO_Out !== lo_m) begin
                miscompares++;
                $display("FAIL rand%0d_result: got %08h/%08h expected %08h/%08h", it, HI_Out, LO_Out, hi_m, lo_m);
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        Start_Mult = 1'b0; Start_Div = 1'b0;
        Mult_HI = '0; Mult_LO = '0; Div_HI = '0; Div_LO = '0;
        Div_Zero = 1'b0; Write_HI = 1'b0; Write_LO = 1'b0; Data_In = '0;
        hi_m = '0; lo_m = '0;
        test_reset();
        test_direct_write();
        test_mult();
        test_div_zero();
        test_same_edge();
        test_ignore_during_run();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
